// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: round-robin write-port arbiter and sequencer for a register file.
// Each cycle it grants up to WRITE of REQ requesters whose target addresses are
// distinct, registers the grants onto the register-file write ports, and reports
// which addresses have a write sitting in the output stage.
//
// Ports:
//   clk        single clock, all state on posedge
//   reset      synchronous active-high reset
//   req_valid  [REQ]        requester i has a write pending
//   req_addr   [REQ][ADDR]  target register of requester i
//   req_data   [REQ][DATA]  write data of requester i
//   req_ready  [REQ]        combinational grant (transfer on valid && ready at posedge)
//   waddr      [WRITE][ADDR] registered write address per port
//   we_        [WRITE]       registered write enable per port, active-low
//   wdata      [WRITE][DATA] registered write data per port
//   pend       [DEPTH]       address a has a write in the output stage
module regfile_wr_arb #(
    parameter int unsigned DATA     = 32,
    parameter int unsigned ADDR     = 4,
    parameter int unsigned REQ      = 4,
    parameter int unsigned WRITE    = 1,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [REQ-1:0]              req_valid,
    input  logic [REQ-1:0][ADDR-1:0]    req_addr,
    input  logic [REQ-1:0][DATA-1:0]    req_data,
    output logic [REQ-1:0]              req_ready,
    output logic [WRITE-1:0][ADDR-1:0]  waddr,
    output logic [WRITE-1:0]            we_,
    output logic [WRITE-1:0][DATA-1:0]  wdata,
    output logic [(2**ADDR)-1:0]        pend
);

    localparam int unsigned DEPTH = 2 ** ADDR;
    localparam int unsigned PTR_W = (REQ > 1) ? $clog2(REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    // State
    logic [PTR_W-1:0]             ptr_q,   ptr_d;
    logic [WRITE-1:0]             we_q,    we_d;
    logic [WRITE-1:0][ADDR-1:0]   waddr_q, waddr_d;
    logic [WRITE-1:0][DATA-1:0]   wdata_q, wdata_d;
    logic [DEPTH-1:0]             pend_q,  pend_d;

    // Grant scan results
    logic [REQ-1:0]               ready_c;
    logic [WRITE-1:0]             slot_used;
    logic [WRITE-1:0][ADDR-1:0]   slot_addr;
    logic [WRITE-1:0][DATA-1:0]   slot_data;

    // Scan temporaries
    logic [SUM_W-1:0]             sum;
    logic [PTR_W-1:0]             idx;
    logic                         hit;
    logic                         placed;

    // Round-robin scan from ptr; slots fill in port order, one per distinct address.
    always_comb begin
        ready_c   = '0;
        slot_used = '0;
        slot_addr = '0;
        slot_data = '0;
        ptr_d     = ptr_q;
        sum       = '0;
        idx       = '0;
        hit       = 1'b0;
        placed    = 1'b0;
        for (int j = 0; j < REQ; j++) begin
            sum = {1'b0, ptr_q} + SUM_W'(j);
            if (sum >= SUM_W'(REQ)) begin
                sum = sum - SUM_W'(REQ);
            end
            idx    = PTR_W'(sum);
            hit    = 1'b0;
            placed = 1'b0;
            if (req_valid[idx] && !reset) begin
                if ((ZERO_REG != 0) && (req_addr[idx] == '0)) begin
                    // Writes to the hardwired-zero register are absorbed without a port.
                    ready_c[idx] = 1'b1;
                end else begin
                    for (int k = 0; k < WRITE; k++) begin
                        if (slot_used[k] && (slot_addr[k] == req_addr[idx])) begin
                            hit = 1'b1;
                        end
                    end
                    if (!hit && !(&slot_used)) begin
                        for (int k = 0; k < WRITE; k++) begin
                            if (!slot_used[k] && !placed) begin
                                slot_used[k] = 1'b1;
                                slot_addr[k] = req_addr[idx];
                                slot_data[k] = req_data[idx];
                                placed       = 1'b1;
                            end
                        end
                        ready_c[idx] = 1'b1;
                        // Last slot-granted requester decides where the next scan starts.
                        ptr_d = (32'(idx) == (REQ - 1)) ? '0 : idx + PTR_W'(1);
                    end
                end
            end
        end
    end

    // Output stage next value; idle ports keep their address/data and deassert we_.
    always_comb begin
        we_d    = '1;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pend_d  = '0;
        for (int k = 0; k < WRITE; k++) begin
            if (slot_used[k]) begin
                we_d[k]    = 1'b0;
                waddr_d[k] = slot_addr[k];
                wdata_d[k] = slot_data[k];
            end
        end
        for (int k = 0; k < WRITE; k++) begin
            if (!we_d[k]) begin
                pend_d[waddr_d[k]] = 1'b1;
            end
        end
    end

    // State registers; reset drops any in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            we_q    <= '1;
            waddr_q <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    assign req_ready = ready_c;
    assign waddr     = waddr_q;
    assign we_       = we_q;
    assign wdata     = wdata_q;
    assign pend      = pend_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Testbench for regfile_wr_arb: two instances (WRITE=1 with ZERO_REG=1, and
// WRITE=2 with ZERO_REG=0) share one requester bus; each scenario observes the
// instance it targets. Small register-file models consume the write ports.
module tb_regfile_wr_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [3:0]        req_valid;
    logic [3:0][3:0]   req_addr;
    logic [3:0][31:0]  req_data;

    logic [3:0]        w1_ready;
    logic [0:0][3:0]   w1_waddr;
    logic [0:0]        w1_we;
    logic [0:0][31:0]  w1_wdata;
    logic [15:0]       w1_pend;

    logic [3:0]        w2_ready;
    logic [1:0][3:0]   w2_waddr;
    logic [1:0]        w2_we;
    logic [1:0][31:0]  w2_wdata;
    logic [15:0]       w2_pend;

    logic [31:0] rf1 [16];
    logic [31:0] rf2 [16];

    int checks = 0;
    int errors = 0;

    regfile_wr_arb #(.DATA(32), .ADDR(4), .REQ(4), .WRITE(1), .ZERO_REG(1)) u_w1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(w1_ready), .waddr(w1_waddr), .we_(w1_we),
        .wdata(w1_wdata), .pend(w1_pend)
    );

    regfile_wr_arb #(.DATA(32), .ADDR(4), .REQ(4), .WRITE(2), .ZERO_REG(0)) u_w2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(w2_ready), .waddr(w2_waddr), .we_(w2_we),
        .wdata(w2_wdata), .pend(w2_pend)
    );

    // Register files held in reset ignore writes.
    always @(posedge clk) begin
        if (!reset) begin
            if (!w1_we[0]) rf1[w1_waddr[0]] <= w1_wdata[0];
            for (int k = 0; k < 2; k++)
                if (!w2_we[k]) rf2[w2_waddr[k]] <= w2_wdata[k];
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 4'(i + 1);
            req_data[i] = 32'(i);
        end
        @(posedge clk); #1;
        checks++; if (w1_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_w1 got=%b exp=0000", w1_ready); end
        checks++; if (w2_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_w2 got=%b exp=0000", w2_ready); end
        checks++; if (w1_we !== 1'b1) begin errors++; $display("FAIL reset_we_w1 got=%b exp=1", w1_we); end
        checks++; if (w2_we !== 2'b11) begin errors++; $display("FAIL reset_we_w2 got=%b exp=11", w2_we); end
        checks++; if (w1_pend !== 16'h0 || w2_pend !== 16'h0) begin errors++; $display("FAIL reset_pend got=%h/%h exp=0", w1_pend, w2_pend); end
        checks++; if (w1_waddr[0] !== 4'h0 || w2_wdata !== 64'h0) begin errors++; $display("FAIL reset_addr_data got=%h/%h exp=0", w1_waddr[0], w2_wdata); end
        reset     = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (w1_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready got=%b exp=0000", w1_ready); end
            @(posedge clk); #1;
            checks++; if (w1_we !== 1'b1 || w1_pend !== 16'h0) begin errors++; $display("FAIL idle_out got=we%b pend%h exp=we1 pend0", w1_we, w1_pend); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_r;
        logic [15:0] exp_p;
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 4'(i + 1);
            req_data[i] = 32'h100 + 32'(i);
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            exp_r = 4'b0001 << (c % 4);
            checks++; if (w1_ready !== exp_r) begin errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, w1_ready, exp_r); end
            @(posedge clk); #1;
            exp_p = 16'h0001 << ((c % 4) + 1);
            checks++; if (w1_we !== 1'b0) begin errors++; $display("FAIL rr_we c=%0d got=%b exp=0", c, w1_we); end
            checks++; if (w1_waddr[0] !== 4'((c % 4) + 1)) begin errors++; $display("FAIL rr_waddr c=%0d got=%0d exp=%0d", c, w1_waddr[0], (c % 4) + 1); end
            checks++; if (w1_wdata[0] !== 32'h100 + 32'(c % 4)) begin errors++; $display("FAIL rr_wdata c=%0d got=%h", c, w1_wdata[0]); end
            checks++; if (w1_pend !== exp_p) begin errors++; $display("FAIL rr_pend c=%0d got=%h exp=%h", c, w1_pend, exp_p); end
        end
    endtask

    task automatic test_conflict();
        do_reset();
        req_valid = 4'b0111;
        req_addr[0] = 4'd5; req_data[0] = 32'hA;
        req_addr[1] = 4'd5; req_data[1] = 32'hB;
        req_addr[2] = 4'd6; req_data[2] = 32'hC;
        #1;
        checks++; if (w2_ready !== 4'b0101) begin errors++; $display("FAIL cf_ready1 got=%b exp=0101", w2_ready); end
        @(posedge clk); #1;
        req_valid = 4'b0010;
        checks++; if (w2_we !== 2'b00) begin errors++; $display("FAIL cf_we1 got=%b exp=00", w2_we); end
        checks++; if (w2_waddr[0] !== 4'd5 || w2_wdata[0] !== 32'hA) begin errors++; $display("FAIL cf_port0 got=%0d/%h exp=5/a", w2_waddr[0], w2_wdata[0]); end
        checks++; if (w2_waddr[1] !== 4'd6 || w2_wdata[1] !== 32'hC) begin errors++; $display("FAIL cf_port1 got=%0d/%h exp=6/c", w2_waddr[1], w2_wdata[1]); end
        checks++; if (w2_pend !== 16'h0060) begin errors++; $display("FAIL cf_pend1 got=%h exp=0060", w2_pend); end
        #1;
        checks++; if (w2_ready !== 4'b0010) begin errors++; $display("FAIL cf_ready2 got=%b exp=0010", w2_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        checks++; if (w2_we !== 2'b10) begin errors++; $display("FAIL cf_we2 got=%b exp=10", w2_we); end
        checks++; if (w2_waddr[0] !== 4'd5 || w2_wdata[0] !== 32'hB) begin errors++; $display("FAIL cf_port0b got=%0d/%h exp=5/b", w2_waddr[0], w2_wdata[0]); end
        checks++; if (w2_waddr[1] !== 4'd6 || w2_wdata[1] !== 32'hC) begin errors++; $display("FAIL cf_hold got=%0d/%h exp=6/c", w2_waddr[1], w2_wdata[1]); end
        checks++; if (w2_pend !== 16'h0020) begin errors++; $display("FAIL cf_pend2 got=%h exp=0020", w2_pend); end
        @(posedge clk); #1;
        checks++; if (w2_we !== 2'b11 || w2_pend !== 16'h0) begin errors++; $display("FAIL cf_idle got=%b/%h exp=11/0", w2_we, w2_pend); end
        checks++; if (rf2[5] !== 32'hB || rf2[6] !== 32'hC) begin errors++; $display("FAIL cf_rf got=%h/%h exp=b/c", rf2[5], rf2[6]); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        req_valid = 4'b0011;
        req_addr[0] = 4'd0; req_data[0] = 32'h11;
        req_addr[1] = 4'd3; req_data[1] = 32'h33;
        #1;
        checks++; if (w1_ready !== 4'b0011) begin errors++; $display("FAIL zr_ready got=%b exp=0011", w1_ready); end
        checks++; if (w2_ready !== 4'b0011) begin errors++; $display("FAIL zr_ready_nozero got=%b exp=0011", w2_ready); end
        @(posedge clk); #1;
        checks++; if (w1_we !== 1'b0 || w1_waddr[0] !== 4'd3 || w1_wdata[0] !== 32'h33) begin errors++; $display("FAIL zr_write got=%b/%0d/%h exp=0/3/33", w1_we, w1_waddr[0], w1_wdata[0]); end
        checks++; if (w1_pend !== 16'h0008) begin errors++; $display("FAIL zr_pend got=%h exp=0008", w1_pend); end
        checks++; if (w2_we !== 2'b00 || w2_waddr[0] !== 4'd0) begin errors++; $display("FAIL zr_nozero_write got=%b/%0d exp=00/0", w2_we, w2_waddr[0]); end
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) req_addr[i] = 4'(12 + i);
        #1;
        checks++; if (w1_ready !== 4'b0100) begin errors++; $display("FAIL zr_ptr got=%b exp=0100", w1_ready); end
    endtask

    task automatic test_latency();
        do_reset();
        req_valid = 4'b0001;
        req_addr[0] = 4'd7; req_data[0] = 32'h1234;
        #1;
        checks++; if (w1_ready !== 4'b0001) begin errors++; $display("FAIL lat_ready got=%b exp=0001", w1_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        checks++; if (w1_we !== 1'b0 || w1_waddr[0] !== 4'd7) begin errors++; $display("FAIL lat_port got=%b/%0d exp=0/7", w1_we, w1_waddr[0]); end
        checks++; if (w1_pend !== 16'h0080) begin errors++; $display("FAIL lat_pend got=%h exp=0080", w1_pend); end
        @(posedge clk); #1;
        checks++; if (rf1[7] !== 32'h1234) begin errors++; $display("FAIL lat_rf got=%h exp=1234", rf1[7]); end
        checks++; if (w1_pend !== 16'h0 || w1_we !== 1'b1) begin errors++; $display("FAIL lat_idle got=%h/%b exp=0/1", w1_pend, w1_we); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        reset = 1'b1;
        req_valid = 4'b0001;
        req_addr[0] = 4'd9; req_data[0] = 32'h99;
        #1;
        checks++; if (w1_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready_in_reset got=%b exp=0000", w1_ready); end
        @(posedge clk); #1;
        checks++; if (w1_we !== 1'b1 || w1_pend !== 16'h0) begin errors++; $display("FAIL rm_not_accepted got=%b/%h exp=1/0", w1_we, w1_pend); end
        reset = 1'b0;
        #1;
        checks++; if (w1_ready !== 4'b0001) begin errors++; $display("FAIL rm_ready got=%b exp=0001", w1_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b1;
        checks++; if (w1_we !== 1'b0) begin errors++; $display("FAIL rm_inflight got=%b exp=0", w1_we); end
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (w1_we !== 1'b1 || w1_pend !== 16'h0) begin errors++; $display("FAIL rm_dropped got=%b/%h exp=1/0", w1_we, w1_pend); end
        @(posedge clk); #1;
        checks++; if (rf1[9] !== 32'h0) begin errors++; $display("FAIL rm_rf got=%h exp=0", rf1[9]); end
    endtask

    // Random requesters that hold until accepted; reference model follows the grant rules.
    task automatic test_random(input int inst, input int ncyc);
        int          w;
        bit          zr;
        int          mptr;
        bit          rst;
        bit          clash;
        int          sl[$];
        logic [1:0]          mwe;
        logic [1:0][3:0]     mwa;
        logic [1:0][31:0]    mwd;
        logic [3:0]          exp_rdy, got_rdy;
        logic [15:0]         exp_pend, got_pend;
        logic [1:0]          got_we;
        logic [1:0][3:0]     got_wa;
        logic [1:0][31:0]    got_wd;
        w  = (inst == 0) ? 1 : 2;
        zr = (inst == 0);
        do_reset();
        mptr = 0; mwe = '1; mwa = '0; mwd = '0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i]  = 4'($urandom_range(0, 5));
                    req_data[i]  = $urandom;
                end
            end
            rst   = ($urandom_range(0, 39) == 0);
            reset = rst;
            #1;
            exp_rdy = '0;
            sl.delete();
            if (!rst) begin
                for (int j = 0; j < 4; j++) begin
                    int i;
                    i = (mptr + j) % 4;
                    if (!req_valid[i]) continue;
                    if (zr && req_addr[i] == 4'd0) begin
                        exp_rdy[i] = 1'b1;
                        continue;
                    end
                    if (sl.size() >= w) continue;
                    clash = 1'b0;
                    foreach (sl[s]) if (req_addr[sl[s]] == req_addr[i]) clash = 1'b1;
                    if (!clash) begin
                        exp_rdy[i] = 1'b1;
                        sl.push_back(i);
                    end
                end
            end
            got_rdy = (inst == 0) ? w1_ready : w2_ready;
            checks++; if (got_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_ready inst=%0d cyc=%0d got=%b exp=%b", inst, c, got_rdy, exp_rdy); end
            @(posedge clk); #1;
            if (rst) begin
                mptr = 0; mwe = '1; mwa = '0; mwd = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (k < sl.size()) begin
                        mwe[k] = 1'b0;
                        mwa[k] = req_addr[sl[k]];
                        mwd[k] = req_data[sl[k]];
                    end else begin
                        mwe[k] = 1'b1;
                    end
                end
                if (sl.size() > 0) mptr = (sl[sl.size() - 1] + 1) % 4;
                for (int i = 0; i < 4; i++) if (exp_rdy[i]) req_valid[i] = 1'b0;
            end
            exp_pend = '0;
            for (int k = 0; k < w; k++) if (!mwe[k]) exp_pend[mwa[k]] = 1'b1;
            got_we   = (inst == 0) ? {1'b1, w1_we[0]} : w2_we;
            got_wa   = (inst == 0) ? {4'h0, w1_waddr[0]} : w2_waddr;
            got_wd   = (inst == 0) ? {32'h0, w1_wdata[0]} : w2_wdata;
            got_pend = (inst == 0) ? w1_pend : w2_pend;
            for (int k = 0; k < w; k++) begin
                checks++; if (got_we[k] !== mwe[k]) begin errors++; $display("FAIL rnd_we inst=%0d cyc=%0d port=%0d got=%b exp=%b", inst, c, k, got_we[k], mwe[k]); end
                checks++; if (got_wa[k] !== mwa[k] || got_wd[k] !== mwd[k]) begin errors++; $display("FAIL rnd_port inst=%0d cyc=%0d port=%0d got=%0d/%h exp=%0d/%h", inst, c, k, got_wa[k], got_wd[k], mwa[k], mwd[k]); end
            end
            checks++; if (got_pend !== exp_pend) begin errors++; $display("FAIL rnd_pend inst=%0d cyc=%0d got=%h exp=%h", inst, c, got_pend, exp_pend); end
        end
        reset     = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 16; a++) begin
            rf1[a] = '0;
            rf2[a] = '0;
        end
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_round_robin();
        test_conflict();
        test_zero_reg();
        test_latency();
        test_reset_mid();
        test_random(0, 400);
        test_random(1, 400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arb.md
# regfile_wr_arb

Write-port arbiter and sequencer for the register file. REQ independent requesters compete for the register file's WRITE write ports through valid/ready handshakes. Each cycle the block grants up to WRITE requests in round-robin order, with distinct target addresses. It registers the grants onto the register file's write port (waddr/we_/wdata, with active-low we_) and tracks which addresses have a write in flight.

## Interface
- DATA, 32, register width; must match the register file.
- ADDR, 4, register address width; DEPTH = 1 << ADDR.
- REQ, 4, number of requesters, ≥ 1.
- WRITE, 1, number of register-file write ports, 1 ≤ WRITE ≤ REQ.
- ZERO_REG, 0, when 1, register 0 is hardwired zero: address-0 requests are absorbed.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  [REQ]  requester i has a write pending.
- req_addr  in  [REQ][ADDR]  target register of requester i.
- req_data  in  [REQ][DATA]  write data of requester i.
- req_ready  out  [REQ]  combinational grant; transfer when valid && ready at posedge.
- waddr  out  [WRITE][ADDR]  registered register-file write address per port.
- we_  out  [WRITE]  registered register-file write enable per port, active-low.
- wdata  out  [WRITE][DATA]  registered register-file write data per port.
- pend  out  [DEPTH]  bit a = 1 while a write to address a sits in the output stage.

## Operation
- State:
  - round-robin pointer ptr, range 0..REQ-1;
  - output-stage registers waddr, we_ and wdata.
- Grant scan, combinational, each cycle: visit requesters in order ptr, ptr+1, …, ptr+REQ-1, all mod REQ.
  - A valid requester is granted if a port slot remains and its address differs from every address already granted this cycle.
  - Slots are filled in port order 0, 1, …, WRITE-1.
- Same-address conflict: the later requester in scan order gets req_ready=0 and retries; it keeps valid asserted and its addr/data stable.
- ZERO_REG=1 and req_addr=0:
  - req_ready=1 whenever valid, independent of free slots;
  - uses no port, produces no register-file write and does not affect pend.
- Output stage update at each posedge:
  - granted port k: waddr[k] ← addr, wdata[k] ← data, we_[k] ← 0;
  - unused port k: we_[k] ← 1, waddr[k] and wdata[k] hold their previous values.
- pend: bit a is 1 iff some port k has we_[k]=0 and waddr[k]=a.
- Pointer update:
  - if ≥ 1 port slot was granted this cycle: ptr ← (index of last slot-granted requester + 1) mod REQ;
  - otherwise ptr holds.
  - Address-0 absorptions do not move ptr.
- req_ready depends combinationally on req_valid and req_addr. Requesters must not derive req_valid from req_ready.
- Throughput: up to WRITE writes per cycle. No requester waits more than ceil(REQ/WRITE) grant cycles while others contend on distinct addresses.

## Timing
- Reset, sampled at posedge with reset=1:
  - ptr=0;
  - we_ = all 1;
  - waddr=0, wdata=0, pend=0.
  - While reset=1, req_ready=0 for all requesters.
- Reset asserted mid-operation: the output stage is cleared on that edge, so any in-flight write is dropped. Requests presented during reset are not accepted.
- Latency:
  - handshake at edge N;
  - waddr/we_/wdata valid during cycle N+1;
  - register file updated at edge N+1;
  - readable from the register file in cycle N+2.
- Back-to-back writes to the same address from one requester on consecutive cycles are allowed. The register file sees them in order.
- pend rises in cycle N+1 and falls after edge N+1, unless it is re-granted.
- With no valid requests: we_ = all 1 from the next cycle and ptr holds.

## Test plan
- Reset, then idle, REQ=4 WRITE=1: we_=1, pend=0, req_ready=0 during reset, ptr=0 → after release with no valid, outputs unchanged.
- All 4 requesters valid continuously with distinct addresses 1..4, WRITE=1 → grants in order 0,1,2,3,0; waddr sequence 1,2,3,4,1 one cycle after each grant; we_=0 every cycle.
- WRITE=2, requesters 0 and 1 both target address 5 (data 0xA, 0xB), requester 2 targets 6 (0xC) → cycle 1 grants 0 and 2, giving ports 5/0xA and 6/0xC. Cycle 2 grants 1, giving 5/0xB. Final register 5 = 0xB.
- ZERO_REG=1, requester 0 at address 0 and requester 1 at address 3, WRITE=1 → both ready in the same cycle; only waddr=3 is written; ptr ← 2.
- Single request addr 7, data 0x1234 at edge N → we_=0, waddr=7, pend[7]=1 in cycle N+1; register-file rdata for address 7 = 0x1234 in cycle N+2; pend=0.
- reset pulsed in the cycle after a grant → we_=1 next cycle and no register-file write occurs.
